dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1, meaning an access request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block can accept a request this cycle.
REQ-007 The block SHALL have port req_wen, input, 1, selecting store (1) or load (0).
REQ-008 The block SHALL have port req_func, input, 3, the RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 The block SHALL have port req_addr, input, 32, the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the requester accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, the extended load result.
REQ-014 The block SHALL have port rsp_err, output, 1, flagging a faulted access.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP; reset state is IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; wen, func, addr and wdata are captured, and the state becomes ACCESS.
REQ-018 ACCESS SHALL last exactly one cycle and then go to RESP.
REQ-019 In ACCESS the block SHALL read the storage word and, for a non-faulting store, write it.
REQ-020 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable until a rising edge with rsp_ready=1; that edge returns the state to IDLE.
REQ-021 The minimum latency from acceptance to rsp_valid SHALL be 2 cycles, giving a throughput of 1 request per 3 cycles.
REQ-022 An offset SHALL be computed as offset = req_addr - BASE_ADDR using 32-bit modular arithmetic.
REQ-023 The word index SHALL be offset[31:2], and the lane SHALL be offset[1:0].
REQ-024 The fault conditions are:
- word index >= DEPTH_WORDS;
- half access with lane[0]=1;
- word access with lane != 0;
- func in {011, 110, 111};
- store with func 100 or 101.
REQ-025 A faulting access SHALL respond with rsp_err=1 and rsp_rdata=0, and SHALL NOT modify storage.
REQ-026 Load results SHALL be formed from the word shifted right by 8*lane:
- lb sign-extends bits [7:0];
- lh sign-extends bits [15:0];
- lw passes 32 bits;
- lbu and lhu zero-extend.
REQ-027 A store SHALL write only the addressed lanes:
- sb writes req_wdata[7:0] into byte lane;
- sh writes req_wdata[15:0] into bytes lane and lane+1;
- sw writes all 4 bytes.
REQ-028 A store SHALL leave the other bytes of the word unchanged.
REQ-029 A non-faulting store SHALL respond with rsp_err=0 and rsp_rdata=0.
REQ-030 A load following a store to the same word SHALL return the updated data; there is no stale read.
REQ-031 req_valid asserted outside IDLE SHALL be ignored, and the requester SHALL hold it until accepted.
REQ-032 In IDLE and ACCESS, rsp_valid, rsp_err and rsp_rdata SHALL be 0.

Reset
REQ-033 While rst=1, the outputs SHALL be req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL rise in the first cycle after rst deasserts.
REQ-034 Reset SHALL NOT clear storage contents.
REQ-035 rst asserted in ACCESS before the commit edge SHALL abort the store with no write; rst asserted in RESP SHALL discard the pending response.

Verification
REQ-036 The bench SHALL cover: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after acceptance.
REQ-037 The bench SHALL cover: after the REQ-036 store, sb 0x12 data 0x80 then lw 0x10 -> 0xDE80BEEF; lb 0x12 -> 0xFFFFFF80; lbu 0x12 -> 0x00000080.
REQ-038 The bench SHALL cover: sh 0x16 data 0x1234, then lh 0x16 -> 0x00001234; lhu 0x15 -> err 1, rdata 0.
REQ-039 The bench SHALL cover: sw 0x21 -> err 1, and a following lw 0x20 returns the previous contents unchanged; sw to byte 4*DEPTH_WORDS -> err 1.
REQ-040 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready 0, and a new req_valid is ignored.
REQ-041 The bench SHALL cover: rst pulsed during ACCESS of sw 0x30 data 0xFFFFFFFF -> outputs 0 immediately, and a later lw 0x30 returns the old value.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one RV32I load/store, accesses storage
// for one cycle, then holds the response until the requester takes it.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        wen_q;
  logic [2:0]  func_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off, word, shifted, st_data, st_word, ld_data;
  logic [29:0] widx;
  logic [1:0]  lane;
  logic        in_range, fault;
  logic [3:0]  be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      func_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        wen_q   <= req_wen;
        func_q  <= req_func;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (fault || wen_q) ? 32'h0 : ld_data;
        err_q   <= fault;
      end
    end
  end

  // Address decode and fault/lane-enable evaluation on the captured request
  assign off      = addr_q - BASE_ADDR;
  assign widx     = off[31:2];
  assign lane     = off[1:0];
  assign in_range = {2'b00, widx} < 32'(DEPTH_WORDS);
  assign word     = in_range ? mem[widx[AW-1:0]] : 32'h0;
  assign shifted  = word >> {lane, 3'b000};
  assign st_data  = wdata_q << {lane, 3'b000};

  always_comb begin
    fault   = !in_range;
    be      = 4'b0000;
    ld_data = 32'h0;
    case (func_q)
      3'b000: begin
        be      = 4'b0001 << lane;
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      3'b001: begin
        fault   = fault | lane[0];
        be      = 4'b0011 << lane;
        ld_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      3'b010: begin
        fault   = fault | (lane != 2'b00);
        be      = 4'b1111;
        ld_data = shifted;
      end
      3'b100: begin
        fault   = fault | wen_q;
        ld_data = {24'h0, shifted[7:0]};
      end
      3'b101: begin
        fault   = fault | wen_q | lane[0];
        ld_data = {16'h0, shifted[15:0]};
      end
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    st_word = word;
    for (int i = 0; i < 4; i++)
      if (be[i]) st_word[8*i +: 8] = st_data[8*i +: 8];
  end

  // A reset during ACCESS drops state to IDLE asynchronously, so the commit edge sees no write
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && wen_q && !fault)
      mem[widx[AW-1:0]] <= st_word;
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses queued at issue, compared at response.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [2:0]  req_func = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic        wen;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } op_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Drives one request from a negedge, returns the response and the acceptance-to-valid latency
  task automatic xact(input op_t o, output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_wen = o.wen; req_func = o.func; req_addr = o.addr; req_wdata = o.wdata;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b valid=%b err=%b rdata=%h want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release got req_ready=%b want 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_word();
    op_t ops[2] = '{
      '{1'b1, FW, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, FW, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0}
    };
    logic [31:0] rd; logic er; int lat; exp_t e;
    foreach (ops[i]) begin
      sb_q.push_back('{ops[i].rdata, ops[i].err});
      xact(ops[i], rd, er, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err) begin
        bad++; $display("FAIL word[%0d] got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
      end
      total++;
      if (lat !== 2) begin
        bad++; $display("FAIL word_latency[%0d] got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_byte_half();
    op_t ops[12] = '{
      '{1'b1, FB,  32'h12, 32'h00000080, 32'h0,        1'b0},
      '{1'b0, FW,  32'h10, 32'h0,        32'hDE80BEEF, 1'b0},
      '{1'b0, FB,  32'h12, 32'h0,        32'hFFFFFF80, 1'b0},
      '{1'b0, FBU, 32'h12, 32'h0,        32'h00000080, 1'b0},
      '{1'b1, FH,  32'h16, 32'h00001234, 32'h0,        1'b0},
      '{1'b0, FH,  32'h16, 32'h0,        32'h00001234, 1'b0},
      '{1'b0, FHU, 32'h15, 32'h0,        32'h0,        1'b1},
      '{1'b1, FW,  32'h18, 32'h11223344, 32'h0,        1'b0},
      '{1'b1, FH,  32'h18, 32'hFFFF8001, 32'h0,        1'b0},
      '{1'b0, FW,  32'h18, 32'h0,        32'h11228001, 1'b0},
      '{1'b0, FH,  32'h18, 32'h0,        32'hFFFF8001, 1'b0},
      '{1'b0, FB,  32'h1B, 32'h0,        32'h00000011, 1'b0}
    };
    logic [31:0] rd; logic er; int lat; exp_t e;
    foreach (ops[i]) begin
      sb_q.push_back('{ops[i].rdata, ops[i].err});
      xact(ops[i], rd, er, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err) begin
        bad++; $display("FAIL byte_half[%0d] got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_faults();
    op_t ops[11] = '{
      '{1'b1, FW,  32'h20,      32'hA5A5A5A5, 32'h0,        1'b0},
      '{1'b1, FW,  32'h21,      32'h00000000, 32'h0,        1'b1},
      '{1'b0, FW,  32'h20,      32'h0,        32'hA5A5A5A5, 1'b0},
      '{1'b1, FW,  4*DEPTH,     32'h00000000, 32'h0,        1'b1},
      '{1'b0, FW,  4*DEPTH,     32'h0,        32'h0,        1'b1},
      '{1'b1, FH,  32'h23,      32'h0000FFFF, 32'h0,        1'b1},
      '{1'b1, FBU, 32'h20,      32'h00000000, 32'h0,        1'b1},
      '{1'b1, FHU, 32'h20,      32'h00000000, 32'h0,        1'b1},
      '{1'b0, 3'b011, 32'h20,   32'h0,        32'h0,        1'b1},
      '{1'b1, 3'b110, 32'h20,   32'h0,        32'h0,        1'b1},
      '{1'b0, FW,  32'h20,      32'h0,        32'hA5A5A5A5, 1'b0}
    };
    logic [31:0] rd; logic er; int lat; exp_t e;
    foreach (ops[i]) begin
      sb_q.push_back('{ops[i].rdata, ops[i].err});
      xact(ops[i], rd, er, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err) begin
        bad++; $display("FAIL fault[%0d] got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat, n; exp_t e;
    op_t chk = '{1'b0, FW, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0};
    sb_q.push_back('{32'hDE80BEEF, 1'b0});
    req_wen = 1'b0; req_func = FW; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    e = sb_q.pop_front();
    // a store attempt during the held response must be ignored
    req_wen = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d] got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    sb_q.push_back('{chk.rdata, chk.err});
    xact(chk, rd, er, lat);
    e = sb_q.pop_front();
    total++;
    if (rd !== e.rdata || er !== e.err) begin
      bad++; $display("FAIL ignored_req got %h/%b want %h/%b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat, n; exp_t e;
    op_t pre = '{1'b1, FW, 32'h30, 32'h01020304, 32'h0, 1'b0};
    op_t ld  = '{1'b0, FW, 32'h30, 32'h0, 32'h01020304, 1'b0};
    xact(pre, rd, er, lat);
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL abort_prestore got err=%b want 0", er); end
    req_wen = 1'b1; req_func = FW; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
      bad++;
      $display("FAIL abort_access_outputs got ready=%b valid=%b err=%b rdata=%h want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got %b want 1", req_ready); end
    @(negedge clk);
    sb_q.push_back('{ld.rdata, ld.err});
    xact(ld, rd, er, lat);
    e = sb_q.pop_front();
    total++;
    if (rd !== e.rdata || er !== e.err) begin
      bad++; $display("FAIL abort_store_kept got %h/%b want %h/%b", rd, er, e.rdata, e.err);
    end
    // reset while a response is pending
    req_wen = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL abort_resp got valid=%b rdata=%h want 0/0", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb_q.push_back('{ld.rdata, ld.err});
    xact(ld, rd, er, lat);
    e = sb_q.pop_front();
    total++;
    if (rd !== e.rdata || er !== e.err || lat !== 2) begin
      bad++; $display("FAIL after_abort got %h/%b lat=%0d want %h/%b lat=2", rd, er, lat, e.rdata, e.err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_faults();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
